// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Resolves B-type branches against the fetch-time prediction. Drives the
// comparator's signed/unsigned mode, decodes funct3 with the returned flags
// into a taken decision, and issues a held PC-redirect handshake on a
// mispredict. Owns a 2-bit-counter branch history table used for fetch
// predictions and saturating branch / mispredict counters.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_fetch_pc, o_pred_taken  fetch-time BHT lookup (combinational)
//   i_br_valid, o_ready       branch handshake
//   i_br_pc, i_br_imm         branch PC and sign-extended B-immediate
//   i_funct3, i_pred_taken    branch type and prediction it was fetched with
//   o_br_un                   comparator mode (1 = unsigned)
//   i_br_less, i_br_equal     comparator flags, sampled with the accept
//   o_resolved, o_taken,
//   o_illegal                 registered outcome, one-cycle pulse per accept
//   o_redirect_valid,
//   o_redirect_pc,
//   i_redirect_ack            redirect request to fetch
//   o_branch_cnt,
//   o_mispred_cnt             saturating performance counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a branch; o_ready = 1
// REDIRECT | mispredict redirect pending; o_ready = 0, waits for ack

module branch_resolve_unit #(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_fetch_pc,
    output logic              o_pred_taken,
    input  logic              i_br_valid,
    output logic              o_ready,
    input  logic [31:0]       i_br_pc,
    input  logic [31:0]       i_br_imm,
    input  logic [2:0]        i_funct3,
    input  logic              i_pred_taken,
    output logic              o_br_un,
    input  logic              i_br_less,
    input  logic              i_br_equal,
    output logic              o_resolved,
    output logic              o_taken,
    output logic              o_illegal,
    output logic              o_redirect_valid,
    output logic [31:0]       o_redirect_pc,
    input  logic              i_redirect_ack,
    output logic [CNT_W-1:0]  o_branch_cnt,
    output logic [CNT_W-1:0]  o_mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } state_t;

    state_t           state;
    logic [1:0]       bht [BHT_ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] br_idx;
    logic             accept;
    logic             legal;
    logic             taken_c;
    logic             mispred_c;
    logic [31:0]      target_c;

    // Upper and byte-offset PC bits do not take part in the BHT index.
    logic             unused_fetch_bits;
    assign unused_fetch_bits = ^{i_fetch_pc[31:IDX_W+2], i_fetch_pc[1:0]};

    assign fetch_idx    = i_fetch_pc[IDX_W+1:2];
    assign br_idx       = i_br_pc[IDX_W+1:2];
    assign o_pred_taken = bht[fetch_idx][1];
    assign o_br_un      = i_funct3[1];
    assign accept       = i_br_valid && o_ready;

    always_comb begin
        legal   = 1'b1;
        taken_c = 1'b0;
        case (i_funct3)
            3'b000:          taken_c = i_br_equal;
            3'b001:          taken_c = !i_br_equal;
            3'b100, 3'b110:  taken_c = i_br_less;
            3'b101, 3'b111:  taken_c = !i_br_less;
            default:         legal   = 1'b0;
        endcase
    end

    assign mispred_c = legal && (taken_c != i_pred_taken);
    assign target_c  = taken_c ? (i_br_pc + i_br_imm) : (i_br_pc + 32'd4);

    // Control FSM with registered outputs and performance counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_IDLE;
            o_ready          <= 1'b1;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_resolved       <= 1'b0;
            o_taken          <= 1'b0;
            o_illegal        <= 1'b0;
            o_branch_cnt     <= '0;
            o_mispred_cnt    <= '0;
        end else begin
            o_resolved <= accept;
            if (accept) begin
                o_taken   <= taken_c;
                o_illegal <= !legal;
            end
            if (accept && legal && (o_branch_cnt != CNT_MAX)) begin
                o_branch_cnt <= o_branch_cnt + CNT_ONE;
            end
            if (accept && mispred_c && (o_mispred_cnt != CNT_MAX)) begin
                o_mispred_cnt <= o_mispred_cnt + CNT_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && mispred_c) begin
                        state            <= ST_REDIRECT;
                        o_ready          <= 1'b0;
                        o_redirect_valid <= 1'b1;
                        o_redirect_pc    <= target_c;
                    end
                end
                ST_REDIRECT: begin
                    if (i_redirect_ack) begin
                        state            <= ST_IDLE;
                        o_ready          <= 1'b1;
                        o_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    o_ready          <= 1'b1;
                    o_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    // BHT training; the lookup port reads the pre-update value in the
    // same cycle because the table is only written at the clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && legal) begin
            if (taken_c) begin
                if (bht[br_idx] != 2'b11) bht[br_idx] <= bht[br_idx] + 2'b01;
            end else begin
                if (bht[br_idx] != 2'b00) bht[br_idx] <= bht[br_idx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int ENTRIES = 16;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic [31:0]    i_fetch_pc = '0;
    logic           o_pred_taken;
    logic           i_br_valid = 1'b0;
    logic           o_ready;
    logic [31:0]    i_br_pc = '0;
    logic [31:0]    i_br_imm = '0;
    logic [2:0]     i_funct3 = '0;
    logic           i_pred_taken = 1'b0;
    logic           o_br_un;
    logic           i_br_less = 1'b0;
    logic           i_br_equal = 1'b0;
    logic           o_resolved;
    logic           o_taken;
    logic           o_illegal;
    logic           o_redirect_valid;
    logic [31:0]    o_redirect_pc;
    logic           i_redirect_ack = 1'b0;
    logic [CW-1:0]  o_branch_cnt;
    logic [CW-1:0]  o_mispred_cnt;

    branch_resolve_unit #(.BHT_ENTRIES(ENTRIES), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_fetch_pc(i_fetch_pc), .o_pred_taken(o_pred_taken),
        .i_br_valid(i_br_valid), .o_ready(o_ready),
        .i_br_pc(i_br_pc), .i_br_imm(i_br_imm), .i_funct3(i_funct3),
        .i_pred_taken(i_pred_taken), .o_br_un(o_br_un),
        .i_br_less(i_br_less), .i_br_equal(i_br_equal),
        .o_resolved(o_resolved), .o_taken(o_taken), .o_illegal(o_illegal),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
        .i_redirect_ack(i_redirect_ack),
        .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int    m_bht [ENTRIES];
    int    m_bcnt, m_mcnt;
    bit    m_pend;
    bit    m_resolved, m_taken, m_illegal;
    logic [31:0] m_rpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
        m_bcnt = 0; m_mcnt = 0; m_pend = 0;
        m_resolved = 0; m_taken = 0; m_illegal = 0; m_rpc = '0;
    endtask

    // Outcome per the ISA: eq/ne on equal flag, lt/ge on less flag.
    task automatic ref_decide(input logic [2:0] f3, input bit less, input bit eq,
                              output bit legal, output bit taken);
        legal = 1; taken = 0;
        case (f3)
            3'd0: taken = eq;
            3'd1: taken = !eq;
            3'd4, 3'd6: taken = less;
            3'd5, 3'd7: taken = !less;
            default: legal = 0;
        endcase
    endtask

    task automatic check_regs();
        chk("ready", o_ready, !m_pend);
        chk("redir_valid", o_redirect_valid, m_pend);
        if (m_pend) chk("redir_pc", o_redirect_pc, m_rpc);
        chk("resolved", o_resolved, m_resolved);
        if (m_resolved) begin
            chk("taken", o_taken, m_taken);
            chk("illegal", o_illegal, m_illegal);
        end
        chk("branch_cnt", o_branch_cnt, m_bcnt);
        chk("mispred_cnt", o_mispred_cnt, m_mcnt);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        bit acc, legal, taken, mis;
        logic [31:0] tgt;
        #1;
        chk("br_un", o_br_un, i_funct3[1]);
        chk("pred", o_pred_taken, m_bht[idx(i_fetch_pc)] >= 2);
        acc = i_br_valid && !m_pend;
        ref_decide(i_funct3, i_br_less, i_br_equal, legal, taken);
        mis = legal && (taken != i_pred_taken);
        tgt = taken ? i_br_pc + i_br_imm : i_br_pc + 32'd4;
        @(posedge i_clk);
        m_resolved = acc;
        if (acc) begin
            m_taken = taken;
            m_illegal = !legal;
            if (legal) begin
                if (m_bcnt < CMAX) m_bcnt++;
                if (mis && m_mcnt < CMAX) m_mcnt++;
                if (taken) m_bht[idx(i_br_pc)] = (m_bht[idx(i_br_pc)] < 3) ? m_bht[idx(i_br_pc)] + 1 : 3;
                else       m_bht[idx(i_br_pc)] = (m_bht[idx(i_br_pc)] > 0) ? m_bht[idx(i_br_pc)] - 1 : 0;
            end
        end
        if (m_pend) begin
            if (i_redirect_ack) m_pend = 0;
        end else if (acc && mis) begin
            m_pend = 1;
            m_rpc = tgt;
        end
        #1;
        check_regs();
    endtask

    task automatic branch(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                          input bit less, input bit eq, input bit pred);
        i_br_valid = 1; i_br_pc = pc; i_br_imm = imm; i_funct3 = f3;
        i_br_less = less; i_br_equal = eq; i_pred_taken = pred; i_fetch_pc = pc;
        cycle();
        i_br_valid = 0; i_redirect_ack = 0;
    endtask

    task automatic drain(input int hold);
        i_redirect_ack = 0;
        for (int k = 0; k < hold; k++) cycle();
        for (int k = 0; k < 8 && m_pend; k++) begin
            i_redirect_ack = 1;
            cycle();
        end
        i_redirect_ack = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1;
        #1;
        check_regs();
        for (int p = 0; p < ENTRIES; p += 5) begin
            i_fetch_pc = 32'(p * 4);
            #1;
            chk("rst_pred", o_pred_taken, 1'b0);
        end
        @(posedge i_clk);
        #1;

        // BHT training at 0x40 with taken BLTs, then not-taken
        for (int k = 0; k < 4; k++) begin
            branch(32'h40, 32'h8, 3'b100, 1, 0, m_bht[idx(32'h40)] >= 2);
            chk("train_up", o_pred_taken, 1'b1);
            drain(0);
        end
        begin
            bit exp_dn [3] = '{1'b1, 1'b0, 1'b0};
            for (int k = 0; k < 3; k++) begin
                branch(32'h40, 32'h8, 3'b100, 0, 0, m_bht[idx(32'h40)] >= 2);
                chk("train_dn", o_pred_taken, exp_dn[k]);
                drain(0);
            end
        end

        // BEQ mispredict, ack held off three cycles
        branch(32'h100, 32'h20, 3'b000, 0, 1, 0);
        chk("beq_taken", o_taken, 1'b1);
        chk("beq_rpc", o_redirect_pc, 32'h120);
        drain(3);
        chk("beq_ready", o_ready, 1'b1);

        // BGEU correctly predicted
        branch(32'h300, 32'h10, 3'b111, 0, 0, 1);
        chk("bgeu_nored", o_redirect_valid, 1'b0);
        drain(0);

        // illegal funct3
        branch(32'h500, 32'h10, 3'b010, 1, 1, 1);
        chk("ill_flag", o_illegal, 1'b1);
        chk("ill_taken", o_taken, 1'b0);
        drain(0);

        // wrap-around not-taken target
        branch(32'hFFFF_FFFC, 32'h40, 3'b001, 0, 1, 1);
        chk("wrap_rpc", o_redirect_pc, 32'h0);
        drain(1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            i_br_valid     = $urandom_range(0, 3) != 0;
            i_br_pc        = {$urandom_range(0, 255), 2'b00} + ((n % 7 == 0) ? 32'hFFFF_FF00 : 32'h0);
            i_br_imm       = $urandom();
            i_funct3       = 3'($urandom_range(0, 7));
            i_br_less      = 1'($urandom_range(0, 1));
            i_br_equal     = 1'($urandom_range(0, 1));
            i_pred_taken   = 1'($urandom_range(0, 1));
            i_redirect_ack = $urandom_range(0, 2) == 0;
            i_fetch_pc     = $urandom_range(0, 1) ? i_br_pc : $urandom();
            cycle();
        end
        i_br_valid = 0;
        drain(0);

        // reset in the middle of a pending redirect to 0x200
        branch(32'h1F0, 32'h10, 3'b000, 0, 1, 0);
        chk("pre_rst_rpc", o_redirect_pc, 32'h200);
        #1;
        i_rst_n = 0;
        #1;
        chk("async_valid", o_redirect_valid, 1'b0);
        chk("async_ready", o_ready, 1'b1);
        chk("async_bcnt", o_branch_cnt, 0);
        chk("async_mcnt", o_mispred_cnt, 0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1;
        for (int p = 0; p < ENTRIES; p += 4) begin
            i_fetch_pc = 32'(p * 4);
            #1;
            chk("post_rst_pred", o_pred_taken, 1'b0);
        end
        @(posedge i_clk);
        #1;
        check_regs();
        for (int n = 0; n < 40; n++) begin
            i_br_valid     = 1'($urandom_range(0, 1));
            i_br_pc        = $urandom();
            i_br_imm       = $urandom();
            i_funct3       = 3'($urandom_range(0, 7));
            i_br_less      = 1'($urandom_range(0, 1));
            i_br_equal     = 1'($urandom_range(0, 1));
            i_pred_taken   = 1'($urandom_range(0, 1));
            i_redirect_ack = 1'($urandom_range(0, 1));
            i_fetch_pc     = i_br_pc;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
